controle_seq: RTL

- Parametrised successor of the calculator sequencer.
- Walks a program of NUM_STEPS operations. For each step it fetches operand A then operand B from the operand ROM, runs an add, sub, multiply or divide, and emits one result per step.
- Multiply and divide are iterative (repeated add / repeated subtract) in an internal sub-module.
- Sits between the shared operand ROM and the result register/display path.

---
 rtl/controle_pkg.sv | 25 ++
 rtl/controle_seq_alu.sv | 128 ++++++++++++
 rtl/controle_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared constants for the calculator sequencer: opcodes, FSM encoding and
// the per-step opcode extractor.
package controle_pkg;

   typedef logic [1:0] opcode_t;

   localparam opcode_t OP_ADD = 2'b00;
   localparam opcode_t OP_SUB = 2'b01;
   localparam opcode_t OP_MUL = 2'b10;
   localparam opcode_t OP_DIV = 2'b11;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH_A = 3'd1;
   localparam logic [2:0] S_FETCH_B = 3'd2;
   localparam logic [2:0] S_LOAD    = 3'd3;
   localparam logic [2:0] S_EXEC    = 3'd4;
   localparam logic [2:0] S_WRITE   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   // Program table is packed two bits per step, step 0 in the LSBs.
   function automatic opcode_t op_of(input logic [31:0] ops, input logic [3:0] k);
      return ops[{k, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/controle_seq_alu.sv
// Iterative ALU: single-cycle add/sub, repeated-add multiply and
// repeated-subtract divide. done pulses for one cycle with res/borrow valid.
module iter_alu
   import controle_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic [2*DATA_W-1:0]   res,
   output logic                  borrow,
   output logic                  done
);

   localparam int RW = 2 * DATA_W;

   logic              mul_run, div_run;
   logic [DATA_W-1:0] cnt, opa, opb, rem, quo;
   logic [RW-1:0]     acc, acc_nxt;

   assign acc_nxt = acc + RW'(opa);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_run <= 1'b0;
         div_run <= 1'b0;
         cnt     <= '0;
         opa     <= '0;
         opb     <= '0;
         rem     <= '0;
         quo     <= '0;
         acc     <= '0;
         res     <= '0;
         borrow  <= 1'b0;
         done    <= 1'b0;
      end else if (clr) begin
         mul_run <= 1'b0;
         div_run <= 1'b0;
         cnt     <= '0;
         opa     <= '0;
         opb     <= '0;
         rem     <= '0;
         quo     <= '0;
         acc     <= '0;
         res     <= '0;
         borrow  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mul_run <= 1'b0;
            div_run <= 1'b0;
            opa     <= a;
            opb     <= b;
            unique case (op)
               OP_ADD: begin
                  res    <= RW'(a) + RW'(b);
                  borrow <= 1'b0;
                  done   <= 1'b1;
               end
               OP_SUB: begin
                  res    <= RW'(a) - RW'(b);
                  borrow <= (a < b);
                  done   <= 1'b1;
               end
               OP_MUL: begin
                  borrow <= 1'b0;
                  if (b == '0) begin
                     res  <= '0;
                     done <= 1'b1;
                  end else begin
                     cnt <= b;
                     if (b == DATA_W'(1)) begin
                        res  <= RW'(a);
                        done <= 1'b1;
                     end else begin
                        // First partial product is taken here, so B cycles total.
                        acc     <= RW'(a);
                        mul_run <= 1'b1;
                     end
                  end
               end
               OP_DIV: begin
                  if (b == '0) begin
                     res    <= {a, {DATA_W{1'b1}}};
                     borrow <= 1'b1;
                     done   <= 1'b1;
                  end else if (a < b) begin
                     res    <= {a, {DATA_W{1'b0}}};
                     borrow <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     // First subtraction folded into the start cycle: quotient+1 cycles.
                     rem     <= a - b;
                     quo     <= DATA_W'(1);
                     div_run <= 1'b1;
                  end
               end
            endcase
         end else if (mul_run) begin
            acc <= acc_nxt;
            cnt <= cnt - DATA_W'(1);
            if (cnt <= DATA_W'(2)) begin
               res     <= acc_nxt;
               borrow  <= 1'b0;
               mul_run <= 1'b0;
               done    <= 1'b1;
            end
         end else if (div_run) begin
            if (rem >= opb) begin
               rem <= rem - opb;
               quo <= quo + DATA_W'(1);
            end else begin
               res     <= {rem, quo};
               borrow  <= 1'b0;
               div_run <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/controle_seq.sv
// Program sequencer: fetches operand pairs from the ROM, runs one ALU op per
// step and presents each result with its step index.
module controle_seq
   import controle_pkg::*;
#(
   parameter int                     DATA_W    = 8,
   parameter int                     ADDR_W    = 9,
   parameter int                     NUM_STEPS = 5,
   parameter int                     BASE_ADDR = 0,
   parameter logic [2*NUM_STEPS-1:0] OPS       = 10'b00_10_01_00_01
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_W-1:0]     rom_data,
   output logic [2*DATA_W-1:0]   res,
   output logic                  res_valid,
   output logic [3:0]            res_step,
   output logic                  borrow,
   output logic                  busy,
   output logic                  done
);

   localparam logic [3:0] LAST = 4'(NUM_STEPS - 1);

   logic [2:0]          state;
   logic [3:0]          step;
   logic [DATA_W-1:0]   a_reg;
   logic [ADDR_W-1:0]   pair_addr;
   logic                alu_start, alu_done, alu_borrow;
   logic [2*DATA_W-1:0] alu_res;

   // Address math is deliberately modulo 2^ADDR_W so a program may wrap the ROM.
   assign pair_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({step, 1'b0});

   always_comb begin
      rom_addr = '0;
      if (state == S_FETCH_A)      rom_addr = pair_addr;
      else if (state == S_FETCH_B) rom_addr = pair_addr + ADDR_W'(1);
   end

   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign alu_start = (state == S_LOAD) && !abort;

   iter_alu #(.DATA_W(DATA_W)) u_alu (
      .clk    (clk),
      .rst    (rst),
      .clr    (abort),
      .start  (alu_start),
      .op     (op_of(32'(OPS), step)),
      .a      (a_reg),
      .b      (rom_data),
      .res    (alu_res),
      .borrow (alu_borrow),
      .done   (alu_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         step      <= '0;
         a_reg     <= '0;
         res       <= '0;
         res_valid <= 1'b0;
         res_step  <= '0;
         borrow    <= 1'b0;
         done      <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         done      <= 1'b0;
         // abort outranks start in IDLE and an ALU completion in EXEC
         if (abort) begin
            state <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: if (start) begin
                  state <= S_FETCH_A;
                  step  <= '0;
               end
               S_FETCH_A: state <= S_FETCH_B;
               S_FETCH_B: begin
                  a_reg <= rom_data;
                  state <= S_LOAD;
               end
               S_LOAD: state <= S_EXEC;
               S_EXEC: if (alu_done) begin
                  res       <= alu_res;
                  borrow    <= alu_borrow;
                  res_step  <= step;
                  res_valid <= 1'b1;
                  state     <= S_WRITE;
               end
               S_WRITE: begin
                  if (step == LAST) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     step  <= step + 4'd1;
                     state <= S_FETCH_A;
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
